// File: rtl/kv_cuckoo_ctrl.sv
// kv_cuckoo_ctrl
//   Two-table cuckoo key/value store controller. Accepts one lookup or insert
//   at a time, drives the shared registered hash unit, and probes and updates
//   two on-chip tables. An insert into two occupied slots starts a bounded
//   eviction chain. Each displaced key is re-hashed through the same hash unit.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_op, req_key, req_val   0 = lookup, 1 = insert; key; value for inserts
//   resp_valid                 one-cycle response strobe
//   resp_hit, resp_fail        key found/updated; insert gave up after MAX_KICKS
//   resp_val                   stored value on lookup hit, else 0
//   hf_key                     key presented to the hash unit
//   hf_hash1, hf_hash2         hash unit outputs (low IDX_W bits index T1/T2)
//   occupancy                  valid entries across both tables
module kv_cuckoo_ctrl #(
  parameter int IDX_W     = 3,
  parameter int MAX_KICKS = 8,
  parameter int HASH_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_key,
  input  logic [31:0]      req_val,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic             resp_fail,
  output logic [31:0]      resp_val,
  output logic [31:0]      hf_key,
  input  logic [31:0]      hf_hash1,
  input  logic [31:0]      hf_hash2,
  output logic [IDX_W+1:0] occupancy
);

  localparam int DEPTH  = 1 << IDX_W;
  localparam int KICK_W = $clog2(MAX_KICKS + 1);
  localparam int LAT_W  = $clog2(HASH_LAT + 1);

  typedef enum logic [2:0] {IDLE, HASH, PROBE, KHASH, KPROBE, RESP} state_t;

  state_t state, state_next;

  logic              op_q;
  logic [31:0]       key_q, val_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [KICK_W-1:0] kick;
  logic              tgt_t2;

  logic [DEPTH-1:0]  t1_valid, t2_valid;
  logic [31:0]       t1_key [DEPTH];
  logic [31:0]       t1_val [DEPTH];
  logic [31:0]       t2_key [DEPTH];
  logic [31:0]       t2_val [DEPTH];

  logic [IDX_W-1:0]  idx1, idx2;
  logic              accept, lat_done, t1_match, t2_match, slot_full;
  logic              wr1, wr2, take1, take2, occ_inc, kick_first, kick_inc;
  logic              go_resp, hit_d, fail_d;
  logic [31:0]       val_d;
  logic              unused_hash_bits;

  assign idx1      = hf_hash1[IDX_W-1:0];
  assign idx2      = hf_hash2[IDX_W-1:0];
  assign unused_hash_bits = ^{hf_hash1[31:IDX_W], hf_hash2[31:IDX_W]};
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign lat_done  = (lat_cnt == LAT_W'(HASH_LAT - 1));
  // key_q always holds the key currently being hashed (request key, later
  // the in-hand evicted key), so the match logic serves both probe states.
  assign t1_match  = t1_valid[idx1] && (t1_key[idx1] == key_q);
  assign t2_match  = t2_valid[idx2] && (t2_key[idx2] == key_q);
  assign slot_full = tgt_t2 ? t2_valid[idx2] : t1_valid[idx1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state plus one-cycle table and response strobes. Every table write
  // stores key_q/val_q. On a swap the old slot content is taken into key_q in
  // the same edge, so the non-blocking update exchanges the two entries.
  always_comb begin
    state_next = state;
    wr1        = 1'b0;
    wr2        = 1'b0;
    take1      = 1'b0;
    take2      = 1'b0;
    occ_inc    = 1'b0;
    kick_first = 1'b0;
    kick_inc   = 1'b0;
    go_resp    = 1'b0;
    hit_d      = 1'b0;
    fail_d     = 1'b0;
    val_d      = '0;
    case (state)
      IDLE:  if (accept) state_next = HASH;
      HASH:  if (lat_done) state_next = PROBE;
      KHASH: if (lat_done) state_next = KPROBE;
      PROBE: begin
        go_resp    = 1'b1;
        state_next = RESP;
        if (!op_q) begin
          if (t1_match) begin
            hit_d = 1'b1;
            val_d = t1_val[idx1];
          end else if (t2_match) begin
            hit_d = 1'b1;
            val_d = t2_val[idx2];
          end
        end else if (t1_match) begin
          wr1   = 1'b1;
          hit_d = 1'b1;
        end else if (t2_match) begin
          wr2   = 1'b1;
          hit_d = 1'b1;
        end else if (!t1_valid[idx1]) begin
          wr1     = 1'b1;
          occ_inc = 1'b1;
        end else if (!t2_valid[idx2]) begin
          wr2     = 1'b1;
          occ_inc = 1'b1;
        end else begin
          // Both candidate slots are taken: displace the T1 occupant.
          wr1        = 1'b1;
          take1      = 1'b1;
          kick_first = 1'b1;
          go_resp    = 1'b0;
          state_next = KHASH;
        end
      end
      KPROBE: begin
        if (!slot_full) begin
          wr1        = !tgt_t2;
          wr2        = tgt_t2;
          occ_inc    = 1'b1;
          go_resp    = 1'b1;
          state_next = RESP;
        end else if (kick == KICK_W'(MAX_KICKS)) begin
          // Give up; the in-hand entry is dropped, so occupancy is unchanged.
          go_resp    = 1'b1;
          fail_d     = 1'b1;
          state_next = RESP;
        end else begin
          wr1        = !tgt_t2;
          wr2        = tgt_t2;
          take1      = !tgt_t2;
          take2      = tgt_t2;
          kick_inc   = 1'b1;
          state_next = KHASH;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, hash-key register, counters, valid bits and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 1'b0;
      key_q      <= '0;
      val_q      <= '0;
      hf_key     <= '0;
      lat_cnt    <= '0;
      kick       <= '0;
      tgt_t2     <= 1'b0;
      t1_valid   <= '0;
      t2_valid   <= '0;
      occupancy  <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_fail  <= 1'b0;
      resp_val   <= '0;
    end else begin
      resp_valid <= go_resp;
      resp_hit   <= hit_d;
      resp_fail  <= fail_d;
      resp_val   <= val_d;
      if (accept) begin
        op_q    <= req_op;
        key_q   <= req_key;
        val_q   <= req_val;
        hf_key  <= req_key;
        lat_cnt <= '0;
        kick    <= '0;
      end else if (take1) begin
        key_q   <= t1_key[idx1];
        val_q   <= t1_val[idx1];
        hf_key  <= t1_key[idx1];
        lat_cnt <= '0;
      end else if (take2) begin
        key_q   <= t2_key[idx2];
        val_q   <= t2_val[idx2];
        hf_key  <= t2_key[idx2];
        lat_cnt <= '0;
      end else if (state == HASH || state == KHASH) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
      if (kick_first) begin
        kick   <= KICK_W'(1);
        tgt_t2 <= 1'b1;
      end else if (kick_inc) begin
        kick   <= kick + KICK_W'(1);
        tgt_t2 <= !tgt_t2;
      end
      if (wr1) t1_valid[idx1] <= 1'b1;
      if (wr2) t2_valid[idx2] <= 1'b1;
      if (occ_inc) occupancy <= occupancy + (IDX_W+2)'(1);
    end
  end

  // Key/value storage needs no reset: the valid bits qualify every read.
  always_ff @(posedge clk) begin
    if (wr1) begin
      t1_key[idx1] <= key_q;
      t1_val[idx1] <= val_q;
    end
    if (wr2) begin
      t2_key[idx2] <= key_q;
      t2_val[idx2] <= val_q;
    end
  end

endmodule

// File: tb/tb_kv_cuckoo_ctrl.sv
// tb_kv_cuckoo_ctrl
//   Self-checking bench for kv_cuckoo_ctrl. A registered stub hash unit uses
//   hash1 = key and hash2 = key >> 3. A behavioural cuckoo-table model
//   supplies every expected response, latency and occupancy.
module tb_kv_cuckoo_ctrl;

  localparam int IDX_W     = 3;
  localparam int MAX_KICKS = 4;
  localparam int HASH_LAT  = 1;
  localparam int DEPTH     = 1 << IDX_W;
  localparam int OCC_W     = IDX_W + 2;
  localparam int TO        = 200;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_op = 1'b0;
  logic [31:0]      req_key = '0;
  logic [31:0]      req_val = '0;
  logic             resp_valid, resp_hit, resp_fail;
  logic [31:0]      resp_val, hf_key;
  logic [31:0]      hf_hash1, hf_hash2;
  logic [OCC_W-1:0] occupancy;

  int cmp_count  = 0;
  int fail_count = 0;

  // Behavioural model state: two tables and an entry count.
  bit          m1_v [DEPTH];
  bit          m2_v [DEPTH];
  logic [31:0] m1_k [DEPTH];
  logic [31:0] m1_d [DEPTH];
  logic [31:0] m2_k [DEPTH];
  logic [31:0] m2_d [DEPTH];
  int          m_occ;

  kv_cuckoo_ctrl #(.IDX_W(IDX_W), .MAX_KICKS(MAX_KICKS), .HASH_LAT(HASH_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_val(req_val),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_fail(resp_fail),
    .resp_val(resp_val), .hf_key(hf_key),
    .hf_hash1(hf_hash1), .hf_hash2(hf_hash2), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hf_hash1 <= hf_key;
    hf_hash2 <= hf_key >> 3;
  end

  function automatic int h1i(input logic [31:0] k);
    return int'(k % 32'(DEPTH));
  endfunction

  function automatic int h2i(input logic [31:0] k);
    return int'((k / 32'd8) % 32'(DEPTH));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m1_v[i] = 0;
      m2_v[i] = 0;
    end
    m_occ = 0;
  endtask

  // Cuckoo algorithm: hit or update, free slot in T1 then T2, otherwise
  // bounce entries between the tables until a free slot or the kick limit.
  task automatic model_req(input bit op, input logic [31:0] key, input logic [31:0] val,
                           output bit hit, output bit fail, output logic [31:0] rval,
                           output int kicks);
    int a, b, idx, tbl;
    logic [31:0] hk, hv, tk, tv;
    bit done;
    a = h1i(key); b = h2i(key);
    hit = 0; fail = 0; rval = '0; kicks = 0;
    if (m1_v[a] && m1_k[a] == key) begin
      hit = 1;
      if (op) m1_d[a] = val; else rval = m1_d[a];
    end else if (m2_v[b] && m2_k[b] == key) begin
      hit = 1;
      if (op) m2_d[b] = val; else rval = m2_d[b];
    end else if (op && !m1_v[a]) begin
      m1_v[a] = 1; m1_k[a] = key; m1_d[a] = val; m_occ++;
    end else if (op && !m2_v[b]) begin
      m2_v[b] = 1; m2_k[b] = key; m2_d[b] = val; m_occ++;
    end else if (op) begin
      hk = key; hv = val; tbl = 1; done = 0;
      while (!done) begin
        idx = (tbl == 1) ? h1i(hk) : h2i(hk);
        if ((tbl == 1) ? !m1_v[idx] : !m2_v[idx]) begin
          if (tbl == 1) begin m1_v[idx] = 1; m1_k[idx] = hk; m1_d[idx] = hv; end
          else          begin m2_v[idx] = 1; m2_k[idx] = hk; m2_d[idx] = hv; end
          m_occ++;
          done = 1;
        end else if (kicks == MAX_KICKS) begin
          fail = 1;
          done = 1;
        end else begin
          if (tbl == 1) begin tk = m1_k[idx]; tv = m1_d[idx]; m1_k[idx] = hk; m1_d[idx] = hv; end
          else          begin tk = m2_k[idx]; tv = m2_d[idx]; m2_k[idx] = hk; m2_d[idx] = hv; end
          hk = tk; hv = tv; kicks++; tbl = 3 - tbl;
        end
      end
    end
  endtask

  // Drives one request starting at a falling edge and returns the response.
  // lat counts rising edges from acceptance to the one sampling resp_valid.
  task automatic do_req(input bit op, input logic [31:0] key, input logic [31:0] val,
                        input bit hold, output bit hit, output bit fail,
                        output logic [31:0] rval, output int lat,
                        output bit busy_ok, output bit clear_ok);
    int waits;
    req_op = op; req_key = key; req_val = val; req_valid = 1'b1;
    hit = 0; fail = 0; rval = '0; lat = -1; busy_ok = 1; clear_ok = 0;
    waits = 0;
    while (!req_ready && waits < TO) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      cmp_count++; fail_count++;
      $display("[TB] FAIL accept_timeout key=%0d: req_ready got 0 want 1", key);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    for (int e = 1; e <= TO; e++) begin
      @(negedge clk);
      if (req_ready) busy_ok = 0;
      if (resp_valid) begin
        lat = e; hit = resp_hit; fail = resp_fail; rval = resp_val;
        break;
      end
    end
    if (lat < 0) begin
      cmp_count++; fail_count++;
      $display("[TB] FAIL resp_timeout key=%0d: resp_valid got 0 want 1", key);
      return;
    end
    @(negedge clk);
    clear_ok = !resp_valid && !resp_hit && !resp_fail && resp_val == 32'd0 && req_ready;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    cmp_count++;
    if ({req_ready, resp_valid, resp_hit, resp_fail} !== 4'b1000) begin
      fail_count++;
      $display("[TB] FAIL reset_flags: got ready/valid/hit/fail=%b want 1000",
               {req_ready, resp_valid, resp_hit, resp_fail});
    end
    cmp_count++;
    if (resp_val !== 32'd0 || hf_key !== 32'd0 || occupancy !== '0) begin
      fail_count++;
      $display("[TB] FAIL reset_values: got resp_val=%h hf_key=%h occ=%0d want 0/0/0",
               resp_val, hf_key, occupancy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset_mid_insert();
    bit h, f, eh, ef, bo, co; logic [31:0] v, ev; int lat, k;
    apply_reset();
    model_req(1, 9, 32'h9, eh, ef, ev, k);
    do_req(1, 9, 32'h9, 0, h, f, v, lat, bo, co);
    model_req(1, 73, 32'h73, eh, ef, ev, k);
    do_req(1, 73, 32'h73, 0, h, f, v, lat, bo, co);
    req_op = 1'b1; req_key = 137; req_val = 32'h137; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    cmp_count++;
    if (hf_key !== 32'd9) begin
      fail_count++;
      $display("[TB] FAIL khash_key: got hf_key=%0d want 9", hf_key);
    end
    rst_n = 1'b0;
    #1;
    cmp_count++;
    if (req_ready !== 1'b1 || occupancy !== '0 || hf_key !== 32'd0) begin
      fail_count++;
      $display("[TB] FAIL midop_reset: got ready=%b occ=%0d hf_key=%0d want 1/0/0",
               req_ready, occupancy, hf_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    cmp_count++;
    if (req_ready !== 1'b1 || occupancy !== '0) begin
      fail_count++;
      $display("[TB] FAIL post_reset: got ready=%b occ=%0d want 1/0", req_ready, occupancy);
    end
    do_req(0, 9, 0, 0, h, f, v, lat, bo, co);
    cmp_count++;
    if (h !== 1'b0 || f !== 1'b0 || v !== 32'd0 || lat != 3) begin
      fail_count++;
      $display("[TB] FAIL post_reset_lookup9: got hit=%b fail=%b val=%h lat=%0d want 0/0/0/3",
               h, f, v, lat);
    end
  endtask

  task automatic test_insert_lookup();
    bit h, f, bo, co; logic [31:0] v; int lat;
    apply_reset();
    do_req(1, 1, 32'hA1, 0, h, f, v, lat, bo, co);
    cmp_count++;
    if (h !== 1'b0 || f !== 1'b0 || lat != 3 || !bo || !co) begin
      fail_count++;
      $display("[TB] FAIL insert1: got hit=%b fail=%b lat=%0d busy_ok=%b clear_ok=%b want 0/0/3/1/1",
               h, f, lat, bo, co);
    end
    do_req(0, 1, 0, 0, h, f, v, lat, bo, co);
    cmp_count++;
    if (h !== 1'b1 || v !== 32'hA1 || lat != 3) begin
      fail_count++;
      $display("[TB] FAIL lookup1: got hit=%b val=%h lat=%0d want 1/a1/3", h, v, lat);
    end
    do_req(0, 2, 0, 0, h, f, v, lat, bo, co);
    cmp_count++;
    if (h !== 1'b0 || v !== 32'd0 || occupancy !== OCC_W'(1)) begin
      fail_count++;
      $display("[TB] FAIL lookup2: got hit=%b val=%h occ=%0d want 0/0/1", h, v, occupancy);
    end
  endtask

  task automatic test_kick();
    bit h, f, bo, co; logic [31:0] v; int lat;
    logic [31:0] keys [3] = '{32'd1, 32'd9, 32'd73};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_req(1, keys[i], keys[i] + 32'h100, 0, h, f, v, lat, bo, co);
      cmp_count++;
      if (h !== 1'b0 || f !== 1'b0 || lat != ((i == 2) ? 5 : 3)) begin
        fail_count++;
        $display("[TB] FAIL kick_insert%0d: got hit=%b fail=%b lat=%0d want 0/0/%0d",
                 keys[i], h, f, lat, (i == 2) ? 5 : 3);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_req(0, keys[i], 0, 0, h, f, v, lat, bo, co);
      cmp_count++;
      if (h !== 1'b1 || v !== keys[i] + 32'h100) begin
        fail_count++;
        $display("[TB] FAIL kick_lookup%0d: got hit=%b val=%h want 1/%h",
                 keys[i], h, v, keys[i] + 32'h100);
      end
    end
    cmp_count++;
    if (occupancy !== OCC_W'(3)) begin
      fail_count++;
      $display("[TB] FAIL kick_occ: got %0d want 3", occupancy);
    end
  endtask

  task automatic test_fail();
    bit h, f, bo, co; logic [31:0] v; int lat, hits;
    logic [31:0] keys [3] = '{32'd9, 32'd73, 32'd137};
    apply_reset();
    for (int i = 0; i < 3; i++) do_req(1, keys[i], keys[i], 0, h, f, v, lat, bo, co);
    cmp_count++;
    if (h !== 1'b0 || f !== 1'b1 || lat != 3 + 2 * MAX_KICKS || occupancy !== OCC_W'(2)) begin
      fail_count++;
      $display("[TB] FAIL fail_insert137: got hit=%b fail=%b lat=%0d occ=%0d want 0/1/%0d/2",
               h, f, lat, occupancy, 3 + 2 * MAX_KICKS);
    end
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      do_req(0, keys[i], 0, 0, h, f, v, lat, bo, co);
      if (h && v === keys[i]) hits++;
    end
    cmp_count++;
    if (hits != 2) begin
      fail_count++;
      $display("[TB] FAIL fail_survivors: got %0d hits want 2", hits);
    end
  endtask

  task automatic test_update();
    bit h, f, bo, co; logic [31:0] v; int lat;
    apply_reset();
    do_req(1, 9, 32'h11, 0, h, f, v, lat, bo, co);
    do_req(1, 9, 32'h22, 0, h, f, v, lat, bo, co);
    cmp_count++;
    if (h !== 1'b1 || f !== 1'b0 || occupancy !== OCC_W'(1)) begin
      fail_count++;
      $display("[TB] FAIL update_resp: got hit=%b fail=%b occ=%0d want 1/0/1", h, f, occupancy);
    end
    do_req(0, 9, 0, 0, h, f, v, lat, bo, co);
    cmp_count++;
    if (h !== 1'b1 || v !== 32'h22) begin
      fail_count++;
      $display("[TB] FAIL update_lookup: got hit=%b val=%h want 1/22", h, v);
    end
  endtask

  task automatic test_back_to_back();
    bit h, f, eh, ef, bo, co, op; logic [31:0] v, ev, key, val; int lat, k;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      op  = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      key = $urandom_range(0, 31);
      val = $urandom;
      model_req(op, key, val, eh, ef, ev, k);
      do_req(op, key, val, 1'b1, h, f, v, lat, bo, co);
      cmp_count++;
      if ({h, f, v} !== {eh, ef, ev} || lat != 3 + 2 * k || occupancy !== OCC_W'(m_occ) || !bo || !co) begin
        fail_count++;
        $display("[TB] FAIL b2b_req%0d op=%0b key=%0d: got hit=%b fail=%b val=%h lat=%0d occ=%0d busy_ok=%b clear_ok=%b want %b/%b/%h/%0d/%0d/1/1",
                 i, op, key, h, f, v, lat, occupancy, bo, co, eh, ef, ev, 3 + 2 * k, m_occ);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    bit h, f, eh, ef, bo, co, op; logic [31:0] v, ev, key, val; int lat, k;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      op  = 1'($urandom_range(0, 1));
      key = $urandom_range(0, 63);
      val = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model_req(op, key, val, eh, ef, ev, k);
      do_req(op, key, val, 1'b0, h, f, v, lat, bo, co);
      cmp_count++;
      if ({h, f, v} !== {eh, ef, ev} || lat != 3 + 2 * k || occupancy !== OCC_W'(m_occ) || !bo || !co) begin
        fail_count++;
        $display("[TB] FAIL rand_req%0d op=%0b key=%0d: got hit=%b fail=%b val=%h lat=%0d occ=%0d busy_ok=%b clear_ok=%b want %b/%b/%h/%0d/%0d/1/1",
                 i, op, key, h, f, v, lat, occupancy, bo, co, eh, ef, ev, 3 + 2 * k, m_occ);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_clear();
    test_reset();
    test_reset_mid_insert();
    test_insert_lookup();
    test_kick();
    test_fail();
    test_update();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
